pwm_audio_out: RTL and testbench
================================

PWM_AUDIO_OUT -- requirements
Module: pwm_audio_out

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 11, giving the sample/duty width in bits.
REQ-002 SHALL have parameter SAT_W, default 16, giving the underrun counter width in bits.
REQ-003 SHALL have port CLK100MHZ  input  1  the single clock, rising edge.
REQ-004 SHALL have port CPU_RESETN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  runs the PWM when high; when low, the output is silent and the amplifier is shut down.
REQ-006 SHALL have port s_valid  input  1  an upstream sample is present.
REQ-007 SHALL have port s_data  input  SAMPLE_W  unsigned sample, midscale = 2^(SAMPLE_W-1).
REQ-008 SHALL have port s_ready  output  1  the block accepts a sample this cycle.
REQ-009 SHALL have port AUD_PWM  output  1  registered PWM audio output.
REQ-010 SHALL have port AUD_SD  output  1  amplifier enable.
REQ-011 SHALL have port period_strobe  output  1  one-cycle pulse on the last cycle of each PWM period.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a period ends with no buffered sample.
REQ-013 SHALL have port underrun_cnt  output  SAT_W  saturating underrun count; present only with PWM_UNDERRUN_CNT_EN.

Function
REQ-014 SHALL buffer samples in a 2-entry FIFO: s_ready = (fill < 2); a push occurs when s_valid and s_ready are both high.
REQ-015 SHALL keep s_ready purely a function of registered fill level, with no combinational path from s_valid.
REQ-016 SHALL run an 11-bit period counter cnt from 0 to 2^SAMPLE_W-1 and wrap to 0, advancing only while enable is high.
REQ-017 SHALL, on the cycle where cnt = 2^SAMPLE_W-1 with enable high, assert period_strobe and load duty from the FIFO head (pop) if fill > 0.
REQ-018 SHALL, if fill = 0 at that cycle, hold the previous duty value and pulse underrun.
REQ-019 SHALL apply a loaded duty starting at the cycle where cnt = 0.
REQ-020 SHALL register AUD_PWM <= (cnt < duty) && enable, giving one cycle of latency from cnt to pin.
REQ-021 SHALL, for duty = 0, hold AUD_PWM low for the whole period.
REQ-022 SHALL, for duty = 2^SAMPLE_W-1, hold AUD_PWM high for 2^SAMPLE_W-1 cycles of every 2^SAMPLE_W.
REQ-023 SHALL decide the push/pop boundary case with registered fill: a push and a period end on the same cycle with fill = 0 is an underrun; the pushed sample stays buffered for the next period.
REQ-024 SHALL allow a push and a pop on the same cycle when fill = 1, leaving fill = 1.
REQ-025 SHALL, while enable is low: hold cnt at 0, drive AUD_PWM = 0 and AUD_SD = 0, keep period_strobe and underrun low, retain duty, and still let the FIFO accept samples.
REQ-026 SHALL drive AUD_SD as the registered value of enable.
REQ-027 SHALL, on an enable rising edge, start a fresh period at cnt = 0 using the retained duty.

Reset
REQ-028 SHALL, on CPU_RESETN low, asynchronously clear: cnt = 0, FIFO empty (s_ready = 1 after release), duty = 2^(SAMPLE_W-1) (1024), AUD_PWM = 0, AUD_SD = 0, period_strobe = 0, underrun = 0, underrun_cnt = 0.
REQ-029 SHALL discard any buffered samples when reset is asserted mid-period; no partial period is resumed.
REQ-030 SHALL release reset synchronously to CLK100MHZ, with the first period starting at cnt = 0.

Configuration
REQ-031 SHALL, with macro PWM_UNDERRUN_CNT_EN defined, provide the underrun_cnt port, incrementing once per underrun pulse and saturating at 2^SAT_W-1.
REQ-032 SHALL, without PWM_UNDERRUN_CNT_EN, omit both the port and its counter logic; all other behaviour is identical.

Structure
REQ-033 SHALL take SAMPLE_W, PERIOD (2^SAMPLE_W), MIDSCALE and FIFO_DEPTH (2) from the shared package pwm_audio_pkg.
REQ-034 SHALL implement the 2-entry buffer as sub-module sample_fifo2, with push/pop/full/empty/head ports; counter, compare and control stay in pwm_audio_out.

Verification
REQ-035 Reset then enable=1 with no samples -> AUD_PWM high 1024 of every 2048 cycles; underrun pulses every 2048 cycles; underrun_cnt counts 1, 2, 3.
REQ-036 Push 0, 2047, 512 back-to-back -> s_ready drops after the 2nd push; consecutive periods show high times 0, 2047, 512 cycles.
REQ-037 Push on the exact cycle cnt = 2047 with FIFO empty -> underrun pulses and duty stays 1024; the next period uses the pushed value.
REQ-038 Deassert enable at cnt = 700 -> AUD_PWM = 0 and AUD_SD = 0 on the next cycle, cnt reads 0; re-enable -> full period at the retained duty, with no strobe during the off time.
REQ-039 Assert CPU_RESETN low mid-period with fill = 2 -> outputs clear immediately; after release s_ready = 1 and duty = 1024.
REQ-040 With PWM_UNDERRUN_CNT_EN and SAT_W = 4, run 20 starved periods -> underrun_cnt holds at 15.

Source files
------------

// File: rtl/pwm_audio_pkg.sv
// Shared constants for the PWM audio output path.
package pwm_audio_pkg;

  // Number of cycles in one PWM period for a given duty width.
  function automatic int unsigned period_of(input int unsigned w);
    return 32'd1 << w;
  endfunction

  localparam int unsigned SAMPLE_W   = 11;
  localparam int unsigned PERIOD     = period_of(SAMPLE_W);
  localparam int unsigned MIDSCALE   = PERIOD / 2;
  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry shift FIFO holding samples ahead of the PWM duty register.
// The head entry and the full/empty flags are all plain registers.
module sample_fifo2 #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  import pwm_audio_pkg::*;

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [1:0]   fill;
  logic [1:0]   fill_next;
  logic [W-1:0] slot1;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next fill level from the qualified push/pop pair.
  always_comb begin
    fill_next = fill;
    case ({do_push, do_pop})
      2'b10:   fill_next = fill + 2'(1);
      2'b01:   fill_next = fill - 2'(1);
      default: fill_next = fill;
    endcase
  end

  // Fill level and its registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      fill  <= fill_next;
      full  <= (fill_next == DEPTH);
      empty <= (fill_next == 2'(0));
    end
  end

  // Data slots: pop shifts slot1 forward, push lands in the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      slot1 <= '0;
    end else if (do_pop) begin
      if (fill == DEPTH) begin
        head <= slot1;
      end else if (do_push) begin
        head <= push_data;
      end
    end else if (do_push) begin
      if (empty) begin
        head <= push_data;
      end else begin
        slot1 <= push_data;
      end
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output: free-running period counter, duty compare and a
// two-sample input buffer. Duty reloads only at period boundaries.
// Optional feature macro: PWM_UNDERRUN_CNT_EN adds the saturating
// underrun_cnt output and its counter.
module pwm_audio_out #(
  parameter int unsigned SAMPLE_W = pwm_audio_pkg::SAMPLE_W,
  parameter int unsigned SAT_W    = 16
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic                enable,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                s_ready,
  output logic                AUD_PWM,
  output logic                AUD_SD,
  output logic                period_strobe,
  output logic                underrun
`ifdef PWM_UNDERRUN_CNT_EN
  ,
  output logic [SAT_W-1:0]    underrun_cnt
`endif
);
  import pwm_audio_pkg::*;

  localparam logic [SAMPLE_W-1:0] CNT_LAST = SAMPLE_W'(period_of(SAMPLE_W) - 1);
  localparam logic [SAMPLE_W-1:0] DUTY_RST = SAMPLE_W'(period_of(SAMPLE_W) / 2);

  // Parameter range checks at elaboration.
  if (SAMPLE_W < 2 || SAMPLE_W > 30) begin : g_bad_sample_w
    $error("pwm_audio_out: SAMPLE_W out of range");
  end
  if (SAT_W < 1) begin : g_bad_sat_w
    $error("pwm_audio_out: SAT_W must be at least 1");
  end

  logic                clk;
  logic                rst_n;
  logic [SAMPLE_W-1:0] cnt;
  logic [SAMPLE_W-1:0] duty;
  logic [SAMPLE_W-1:0] head;
  logic                full;
  logic                empty;
  logic                period_end;
  logic                starve;
  logic                push;
  logic                pop;

  assign clk   = CLK100MHZ;
  assign rst_n = CPU_RESETN;

  // Boundary decisions use the registered FIFO flags only, so a push on the
  // last cycle of a starved period still counts as an underrun.
  assign period_end = enable && (cnt == CNT_LAST);
  assign starve     = period_end && empty;
  assign pop        = period_end && !empty;
  assign push       = s_valid && !full;
  assign s_ready    = !full;

  sample_fifo2 #(
    .W (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // Period counter: runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + SAMPLE_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Duty register: reloads from the buffer head at the end of each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= DUTY_RST;
    end else if (pop) begin
      duty <= head;
    end
  end

  // Pin-side outputs, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AUD_PWM       <= 1'b0;
      AUD_SD        <= 1'b0;
      period_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      AUD_PWM       <= enable && (cnt < duty);
      AUD_SD        <= enable;
      period_strobe <= period_end;
      underrun      <= starve;
    end
  end

`ifdef PWM_UNDERRUN_CNT_EN
  localparam logic [SAT_W-1:0] UCNT_MAX = '1;

  // Saturating count of starved periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (starve && (underrun_cnt != UCNT_MAX)) begin
      underrun_cnt <= underrun_cnt + SAT_W'(1);
    end
  end
`else
  // No underrun counter in this build.
`endif

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: a period-position model with a sample queue is
// checked against the DUT every cycle, plus directed literal expectations.
module tb_pwm_audio_out;
  localparam int unsigned W   = 11;
  localparam int          PER = 2048;
`ifdef PWM_UNDERRUN_CNT_EN
  localparam int unsigned SW  = 4;
`else
  localparam int unsigned SW  = 16;
`endif
  localparam int UMAX = (1 << SW) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_ready;
  logic         aud_pwm;
  logic         aud_sd;
  logic         period_strobe;
  logic         underrun;
`ifdef PWM_UNDERRUN_CNT_EN
  logic [SW-1:0] underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_audio_out #(
    .SAMPLE_W (W),
    .SAT_W    (SW)
  ) dut (
    .CLK100MHZ     (clk),
    .CPU_RESETN    (rst_n),
    .enable        (enable),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .AUD_PWM       (aud_pwm),
    .AUD_SD        (aud_sd),
    .period_strobe (period_strobe),
    .underrun      (underrun)
`ifdef PWM_UNDERRUN_CNT_EN
    ,
    .underrun_cnt  (underrun_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the current period, duty in use, queued samples.
  int m_pos  = 0;
  int m_duty = PER / 2;
  int m_q[$];
  bit e_pwm = 0, e_sd = 0, e_strobe = 0, e_under = 0;
  int e_ucnt = 0;
  bit m_fin, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_duty = PER / 2; m_q.delete();
      e_pwm = 0; e_sd = 0; e_strobe = 0; e_under = 0; e_ucnt = 0;
    end else begin
      m_fin = enable && (m_pos == PER - 1);
      m_acc = s_valid && (m_q.size() < 2);
      e_pwm = enable && (m_pos < m_duty);
      e_sd = enable;
      e_strobe = m_fin;
      e_under = m_fin && (m_q.size() == 0);
      if (e_under && e_ucnt < UMAX) e_ucnt++;
      if (m_fin && m_q.size() > 0) m_duty = m_q.pop_front();
      if (m_acc) m_q.push_back(int'(s_data));
      m_pos = enable ? (m_pos + 1) % PER : 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("pwm", int'(aud_pwm), int'(e_pwm));
    chk("sd", int'(aud_sd), int'(e_sd));
    chk("strobe", int'(period_strobe), int'(e_strobe));
    chk("underrun", int'(underrun), int'(e_under));
    chk("ready", int'(s_ready), int'(m_q.size() < 2));
`ifdef PWM_UNDERRUN_CNT_EN
    chk("ucnt", int'(underrun_cnt), e_ucnt);
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the next strobe; returns how many cycles it took.
  task automatic wait_strobe(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!period_strobe && cycles < 5000);
    if (!period_strobe) chk({name, " timeout"}, 0, 1);
  endtask

  // Counts pin-high cycles over the next full period, which must end on a strobe.
  task automatic measure(input string name, input int exp_high, input int exp_under);
    int hi;
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (i == 0) s_valid = 1'b0;
      if (aud_pwm) hi++;
    end
    chk({name, " high"}, hi, exp_high);
    chk({name, " strobe"}, int'(period_strobe), 1);
    chk({name, " underrun"}, int'(underrun), exp_under);
  endtask

  task automatic chk_ucnt(input string name, input int exp);
`ifdef PWM_UNDERRUN_CNT_EN
    chk(name, int'(underrun_cnt), exp);
`else
    if (name.len() < 0 || exp < 0) $display("unused");
`endif
  endtask

  initial begin
    int cyc;
    int off_events;

    // Reset state.
    tick(3);
    chk("rst pwm", int'(aud_pwm), 0);
    chk("rst sd", int'(aud_sd), 0);
    chk("rst strobe", int'(period_strobe), 0);
    chk("rst underrun", int'(underrun), 0);
    rst_n = 1'b1;
    tick(2);
    chk("post-rst ready", int'(s_ready), 1);
    chk_ucnt("post-rst ucnt", 0);

    // Starved running at midscale.
    enable = 1'b1;
    wait_strobe("first strobe", cyc);
    chk("first period length", cyc, PER);
    chk("first underrun", int'(underrun), 1);
    chk_ucnt("ucnt 1", 1);
    measure("starved a", 1024, 1);
    chk_ucnt("ucnt 2", 2);
    measure("starved b", 1024, 1);
    chk_ucnt("ucnt 3", 3);

    // Push on the last cycle of a starved period.
    tick(PER - 1);
    s_valid = 1'b1; s_data = 11'd300;
    tick(1);
    s_valid = 1'b0;
    chk("late push strobe", int'(period_strobe), 1);
    chk("late push underrun", int'(underrun), 1);
    measure("held midscale", 1024, 0);
    measure("late sample", 300, 1);

    // Three back-to-back pushes, the third stalls until a pop.
    s_valid = 1'b1; s_data = 11'd0;
    tick(1);
    s_data = 11'd2047;
    tick(1);
    chk("ready after two", int'(s_ready), 0);
    s_data = 11'd512;
    cyc = 0;
    while (!s_ready && cyc < 5000) begin
      tick(1);
      cyc++;
    end
    chk("ready returns at strobe", int'(period_strobe), 1);
    measure("duty 0", 0, 0);
    measure("duty 2047", 2047, 0);
    measure("duty 512", 512, 1);

    // Disable mid-period, push while off, then re-enable.
    tick(700);
    enable = 1'b0;
    tick(1);
    chk("off pwm", int'(aud_pwm), 0);
    chk("off sd", int'(aud_sd), 0);
    s_valid = 1'b1; s_data = 11'd100;
    tick(1);
    s_valid = 1'b0;
    off_events = 0;
    repeat (300) begin
      tick(1);
      if (period_strobe || underrun) off_events++;
    end
    chk("off strobes", off_events, 0);
    enable = 1'b1;
    measure("re-enable", 512, 0);
    measure("sample while off", 100, 1);

    // Reset mid-period with two buffered samples.
    s_valid = 1'b1; s_data = 11'd50;
    tick(1);
    s_data = 11'd60;
    tick(1);
    s_valid = 1'b0;
    chk("full before reset", int'(s_ready), 0);
    tick(48);
    chk("pwm high before reset", int'(aud_pwm), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async clr pwm", int'(aud_pwm), 0);
    chk("async clr sd", int'(aud_sd), 0);
    chk("async clr ready", int'(s_ready), 1);
    tick(3);
    rst_n = 1'b1;
    measure("post reset", 1024, 1);
    chk_ucnt("ucnt after reset", 1);

`ifdef PWM_UNDERRUN_CNT_EN
    for (int i = 0; i < 20; i++) measure("sat run", 1024, 1);
    chk_ucnt("ucnt saturated", 15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
